// File: rtl/projectile_engine.sv
// Multi-slot projectile controller: synchronises the frame strobe and fire
// buttons, allocates/moves/bounces projectiles and answers per-pixel hit
// queries with registered sprite ROM offsets.
module projectile_engine #(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned BOUNCE      = 1,
  parameter int unsigned SPEED       = 1,
  parameter int unsigned B_W         = 40,
  parameter int unsigned B_H         = 10,
  parameter int unsigned LEFT_LIMIT  = 10,
  parameter int unsigned RIGHT_LIMIT = 639,
  parameter int unsigned L_X         = 90,
  parameter int unsigned L_Y         = 52,
  parameter int unsigned R_X         = 510,
  parameter int unsigned R_Y         = 432
) (
  input  logic                 vga_clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 fire_l_n,
  input  logic                 fire_r_n,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic                 hit,
  output logic [2:0]           hit_slot,
  output logic                 hit_dir,
  output logic [5:0]           hit_offx,
  output logic [3:0]           hit_offy,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 drop_pulse
);

  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [10:0] BW1   = 11'(B_W - 1);
  localparam logic [10:0] BH1   = 11'(B_H - 1);
  localparam logic [10:0] LLIM  = 11'(LEFT_LIMIT);
  localparam logic [10:0] RLIM  = 11'(RIGHT_LIMIT);
  localparam logic [9:0]  RSTOP = 10'(RIGHT_LIMIT - B_W + 1);

  logic [1:0] frame_sync, fl_sync, fr_sync;
  logic       frame_prev, fl_prev, fr_prev;
  logic       tick, fire_l, fire_r;

  logic [NUM_SLOTS-1:0] active, active_n, dir, dir_n;
  logic [9:0]           pos_x [NUM_SLOTS];
  logic [9:0]           pos_y [NUM_SLOTS];
  logic [9:0]           pos_x_n [NUM_SLOTS];
  logic [9:0]           pos_y_n [NUM_SLOTS];
  logic                 drop_n, l_done, r_done;
  logic [10:0]          nx;

  logic       hit_n, hd_n;
  logic [2:0] hs_n;
  logic [5:0] hox_n;
  logic [3:0] hoy_n;

  // Two-stage synchronisers plus edge registers for the three async inputs
  always_ff @(posedge vga_clk) begin
    if (!Reset) begin
      frame_sync <= '0;
      frame_prev <= 1'b0;
      fl_sync    <= '1;
      fl_prev    <= 1'b1;
      fr_sync    <= '1;
      fr_prev    <= 1'b1;
    end else begin
      frame_sync <= {frame_sync[0], frame_clk};
      frame_prev <= frame_sync[1];
      fl_sync    <= {fl_sync[0], fire_l_n};
      fl_prev    <= fl_sync[1];
      fr_sync    <= {fr_sync[0], fire_r_n};
      fr_prev    <= fr_sync[1];
    end
  end

  assign tick   = frame_sync[1] & ~frame_prev;
  assign fire_l = ~fl_sync[1] & fl_prev;
  assign fire_r = ~fr_sync[1] & fr_prev;

  // Slot update: movement of active slots, then allocation into slots that
  // were inactive before this edge, so freed slots wait one cycle
  always_comb begin
    active_n = active;
    dir_n    = dir;
    pos_x_n  = pos_x;
    pos_y_n  = pos_y;
    l_done   = 1'b0;
    r_done   = 1'b0;
    nx       = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (tick && active[i]) begin
        if (!dir[i]) begin
          nx = {1'b0, pos_x[i]} + SPD;
          if (nx + BW1 > RLIM) begin
            if (BOUNCE != 0) begin
              pos_x_n[i] = RSTOP;
              dir_n[i]   = 1'b1;
            end else begin
              active_n[i] = 1'b0;
            end
          end else begin
            pos_x_n[i] = nx[9:0];
          end
        end else begin
          if ({1'b0, pos_x[i]} < LLIM + SPD) begin
            if (BOUNCE != 0) begin
              pos_x_n[i] = 10'(LEFT_LIMIT);
              dir_n[i]   = 1'b0;
            end else begin
              active_n[i] = 1'b0;
            end
          end else begin
            pos_x_n[i] = pos_x[i] - SPD[9:0];
          end
        end
      end
    end
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!active[i]) begin
        if (fire_l && !l_done) begin
          l_done      = 1'b1;
          active_n[i] = 1'b1;
          dir_n[i]    = 1'b0;
          pos_x_n[i]  = 10'(L_X);
          pos_y_n[i]  = 10'(L_Y);
        end else if (fire_r && !r_done) begin
          r_done      = 1'b1;
          active_n[i] = 1'b1;
          dir_n[i]    = 1'b1;
          pos_x_n[i]  = 10'(R_X);
          pos_y_n[i]  = 10'(R_Y);
        end
      end
    end
    drop_n = (fire_l && !l_done) || (fire_r && !r_done);
  end

  // Hit test against pre-update slot state; lowest active slot wins
  always_comb begin
    hit_n = 1'b0;
    hs_n  = '0;
    hd_n  = 1'b0;
    hox_n = '0;
    hoy_n = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!hit_n && active[i] &&
          DrawX >= pos_x[i] && {1'b0, DrawX} <= {1'b0, pos_x[i]} + BW1 &&
          DrawY >= pos_y[i] && {1'b0, DrawY} <= {1'b0, pos_y[i]} + BH1) begin
        hit_n = 1'b1;
        hs_n  = 3'(i);
        hd_n  = dir[i];
        hox_n = DrawX[5:0] - pos_x[i][5:0];
        hoy_n = DrawY[3:0] - pos_y[i][3:0];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge vga_clk) begin
    if (!Reset) begin
      active     <= '0;
      dir        <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
      drop_pulse <= 1'b0;
      hit        <= 1'b0;
      hit_slot   <= '0;
      hit_dir    <= 1'b0;
      hit_offx   <= '0;
      hit_offy   <= '0;
    end else begin
      active     <= active_n;
      dir        <= dir_n;
      pos_x      <= pos_x_n;
      pos_y      <= pos_y_n;
      drop_pulse <= drop_n;
      hit        <= hit_n;
      hit_slot   <= hs_n;
      hit_dir    <= hd_n;
      hit_offx   <= hox_n;
      hit_offy   <= hoy_n;
    end
  end

  assign active_mask = active;

endmodule

// File: doc/projectile_engine.md
Name: projectile_engine

Overview:
Parametrised multi-slot projectile controller for the turret game layer. It holds up to NUM_SLOTS independent projectiles fired from the left and right turrets. Every frame tick it advances each projectile horizontally and applies bounce or despawn at the playfield limits. It also answers the per-pixel question "is a projectile here", returning ROM offsets for the sprite compositor.

Parameters:
NUM_SLOTS, 4, number of concurrent projectiles (1..8)
BOUNCE, 1, 1 = reverse direction at limits; 0 = despawn at limits
SPEED, 1, pixels moved per frame tick (1..15)
B_W, 40, sprite width in pixels (≤64)
B_H, 10, sprite height in pixels (≤16)
LEFT_LIMIT, 10, leftmost allowed pos_x
RIGHT_LIMIT, 639, rightmost allowed sprite pixel column
L_X, 90, left-turret launch x
L_Y, 52, left-turret launch y
R_X, 510, right-turret launch x
R_Y, 432, right-turret launch y

Ports:
vga_clk  in  1  sole clock
Reset  in  1  synchronous, active-low reset
frame_clk  in  1  frame strobe; sampled as data, not used as a clock
fire_l_n  in  1  left fire pushbutton, active-low
fire_r_n  in  1  right fire pushbutton, active-low
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
hit  out  1  registered: pixel lies inside an active projectile
hit_slot  out  3  index of the hit slot
hit_dir  out  1  direction of the hit slot (0 = rightward, 1 = leftward; selects the normal or 180° sprite)
hit_offx  out  6  DrawX − pos_x of the hit slot
hit_offy  out  4  DrawY − pos_y of the hit slot
active_mask  out  NUM_SLOTS  per-slot active bits
drop_pulse  out  1  one-cycle pulse when a fire request finds no free slot

Behaviour:
- Reset (Reset=0 at a vga_clk edge):
  - All slots inactive; pos and dir cleared.
  - All outputs 0.
  - frame_clk synchroniser stages reset to 0; fire synchroniser stages reset to 1.
  - Reset mid-flight: active_mask=0 after that edge, no residual motion.
- Input conditioning:
  - frame_clk, fire_l_n and fire_r_n each pass through a 2-FF synchroniser and an edge register.
  - tick = rising edge of frame_clk; fire_l / fire_r = falling edges of the buttons.
  - Each event is a one-cycle pulse; its effect is visible at the 3rd vga_clk edge after the input transition.
  - A held button fires once.
- Per-slot state: active, dir, pos_x[9:0], pos_y[9:0].
- Movement (on tick only, active slots only); all arithmetic is 11-bit unsigned, no wrap:
  - Rightward: nx = pos_x + SPEED. If nx + B_W − 1 > RIGHT_LIMIT:
    - BOUNCE=1: pos_x := RIGHT_LIMIT − B_W + 1 (600 at defaults), dir := 1.
    - BOUNCE=0: active := 0.
    - Otherwise pos_x := nx.
  - Leftward: if pos_x < LEFT_LIMIT + SPEED:
    - BOUNCE=1: pos_x := LEFT_LIMIT, dir := 0.
    - BOUNCE=0: active := 0.
    - Otherwise pos_x := pos_x − SPEED.
  - A clamp-and-flip tick consumes that tick: no motion in the new direction until the next tick.
  - pos_y is never modified.
- Allocation:
  - fire_l takes the lowest inactive slot: pos = (L_X, L_Y), dir 0.
  - fire_r takes the next lowest inactive slot: pos = (R_X, R_Y), dir 1.
  - If both fire in the same cycle, fire_l has priority.
  - No free slot: request dropped, drop_pulse=1 for one cycle. Two requests dropped in one cycle still give one pulse.
  - A slot allocated on a tick cycle is not moved on that tick.
  - A slot freed by despawn on a tick cycle is not reallocatable until the next cycle.
- Hit test:
  - Inclusive box: pos_x ≤ DrawX ≤ pos_x + B_W − 1 and pos_y ≤ DrawY ≤ pos_y + B_H − 1, active slots only.
  - On overlap, the lowest index wins.
  - All hit outputs registered: latency 1 vga_clk cycle.
  - hit=0 forces hit_slot, hit_dir, hit_offx and hit_offy to 0.
  - The hit test reads slot state as it stands before the current edge's update.

Test Plan:
- Reset, pulse fire_l_n low for 5 cycles → active_mask=0001 at 3rd edge after the fall; slot0 at (90,52), dir 0; held low gives no 2nd slot.
- After fire_l, 510 ticks → pos_x=600, dir 0. 511th tick → pos_x=600, dir 1. 512th tick → pos_x=599.
- Slot0 at (90,52): DrawX/DrawY = 90/52 → next cycle hit=1, offx=0, offy=0. 129/61 → hit=1, offx=39, offy=9. 130/61 → hit=0. 90/62 → hit=0.
- 5 fire_l events with no ticks → active_mask=1111; 5th gives drop_pulse=1 for exactly 1 cycle.
- BOUNCE=0, fire_r → 500 ticks give pos_x=10; 501st tick clears active_mask bit 0.
- fire_l and fire_r on the same cycle from empty → slot0 (90,52) dir 0, slot1 (510,432) dir 1. Then Reset=0 for one edge → active_mask=0, hit=0.
